// File: rtl/pipe_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_mem_arbiter
//
// Shares one single-port, fixed-latency unified RAM between the pipeline's
// instruction-fetch (IF) and data-memory (MEM) stages. Only one access is in
// flight at a time. MEM normally wins an arbitration. IF wins when MEM is not
// competing, or once IF has lost STARVE_MAX arbitrations in a row. The
// winner's address, write enable and write data are registered onto the RAM
// port for exactly LAT cycles. The read data is then captured and the owner's
// ready output pulses for one cycle.
//
// Parameters:
//   AW          address width
//   DW          data width
//   LAT         RAM read latency in cycles (>= 1)
//   STARVE_MAX  consecutive IF losses before IF is forced to win once (>= 1)
//
// Ports:
//   clk, clrn                    clock, synchronous active-high reset
//   if_req, if_addr              fetch request and fetch address
//   if_ready, if_rdata           fetch-done pulse and fetched word (held)
//   mem_req, mem_we              data request and store select (1 = store)
//   mem_addr, mem_wdata          data address and store data
//   mem_ready, mem_rdata         data-done pulse and load data (held)
//   ram_en, ram_we               RAM access enable and write enable
//   ram_addr, ram_wdata          RAM address and write data
//   ram_rdata                    RAM read data
//   pipe_stall                   freezes the pipeline while a requester waits
//   perf_if_wait, perf_mem_wait  saturating wait-cycle counters
//
// Optional feature: define ARB_PERF_CNT_EN to build the two wait-cycle
// counters. Without it, both counter ports are tied to zero.
// ---------------------------------------------------------------------------
module pipe_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ready,
  output logic [DW-1:0] mem_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          pipe_stall,
  output logic [31:0]   perf_if_wait,
  output logic [31:0]   perf_mem_wait
);

  // The down-counter holds LAT-1. Keep it at least one bit wide when LAT is 1.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   starve_q;
  logic            if_eligible;
  logic            mem_eligible;
  logic            if_win;
  logic            mem_win;

  // A requester whose ready pulse is high this cycle is still holding its old
  // request, so it must not be granted again.
  assign if_eligible  = if_req  & ~if_ready;
  assign mem_eligible = mem_req & ~mem_ready;

  assign pipe_stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next state. IF wins when it is alone, or when the
  // starvation counter has saturated. Otherwise MEM takes priority.
  always_comb begin
    state_d = state_q;
    if_win  = 1'b0;
    mem_win = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_eligible && (!mem_eligible || starve_q == SW'(STARVE_MAX))) begin
          if_win  = 1'b1;
          state_d = BUSY_IF;
        end else if (mem_eligible) begin
          mem_win = 1'b1;
          state_d = BUSY_MEM;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. The grant latches the request onto the RAM port, and the port
  // stays frozen for LAT cycles. On the final busy edge, read data is captured
  // and the owner's ready pulse is raised. A store leaves mem_rdata untouched.
  always_ff @(posedge clk) begin
    if (clrn) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_win) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= if_addr;
            cnt_q    <= CW'(LAT - 1);
            starve_q <= '0;
          end else if (mem_win) begin
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            cnt_q     <= CW'(LAT - 1);
            if (if_eligible) begin
              starve_q <= starve_q + 1'b1;
            end
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (cnt_q == '0) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (state_q == BUSY_IF) begin
              if_rdata <= ram_rdata;
              if_ready <= 1'b1;
            end else begin
              mem_ready <= 1'b1;
              if (!ram_we) begin
                mem_rdata <= ram_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Wait-cycle counters. They count every cycle a requester is held off, and
  // they stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clrn) begin
      perf_if_wait  <= '0;
      perf_mem_wait <= '0;
    end else begin
      if ((if_req & ~if_ready) && perf_if_wait != '1) begin
        perf_if_wait <= perf_if_wait + 32'd1;
      end
      if ((mem_req & ~mem_ready) && perf_mem_wait != '1) begin
        perf_mem_wait <= perf_mem_wait + 32'd1;
      end
    end
  end
`else
  assign perf_if_wait  = '0;
  assign perf_mem_wait = '0;
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipe_mem_arbiter
//
// Directed testbench for pipe_mem_arbiter with default parameters:
// LAT = 2 and STARVE_MAX = 4.
//
// The RAM model registers its read data once per enabled cycle. Data read in
// the first enable cycle is therefore present on ram_rdata during the second
// (last) enable cycle. Unwritten locations read as 0xA50000xx, where xx is
// the low address byte.
//
// Cycle numbering: cycle k starts at a rising edge. Inputs change 1 ns after
// that edge, and outputs are sampled on the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_pipe_mem_arbiter;

  logic        clk;
  logic        clrn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        pipe_stall;
  logic [31:0] perf_if_wait;
  logic [31:0] perf_mem_wait;

  int errors;
  int checks;

  pipe_mem_arbiter dut (
    .clk          (clk),
    .clrn         (clrn),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .pipe_stall   (pipe_stall),
    .perf_if_wait (perf_if_wait),
    .perf_mem_wait(perf_mem_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default contents of a location that has never been written.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    return 32'hA500_0000 | {24'h0, a};
  endfunction

  // Small RAM model: 256 words, indexed by the low address byte.
  logic [31:0] ram_store   [0:255];
  logic        ram_written [0:255];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_store[ram_addr[7:0]]   <= ram_wdata;
        ram_written[ram_addr[7:0]] <= 1'b1;
      end
      ram_rdata <= (ram_written[ram_addr[7:0]] === 1'b1) ? ram_store[ram_addr[7:0]]
                                                         : init_val(ram_addr[7:0]);
    end
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and leaves the bench at the start of cycle 0,
  // with reset released.
  task automatic apply_reset();
    clrn      = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tick();
    tick();
    clrn = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset ram_en: got %b want 0", ram_en); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset ram_we: got %b want 0", ram_we); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset ram_addr: got %h want 0", ram_addr); end
    checks++; if (ram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset ram_wdata: got %h want 0", ram_wdata); end
    checks++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset ready: got if=%b mem=%b want 0/0", if_ready, mem_ready); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset if_rdata: got %h want 0", if_rdata); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset mem_rdata: got %h want 0", mem_rdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset pipe_stall: got %b want 0", pipe_stall); end
    checks++; if (perf_if_wait !== 32'h0 || perf_mem_wait !== 32'h0) begin errors++; $display("[TB] FAIL reset perf: got if=%0d mem=%0d want 0/0", perf_if_wait, perf_mem_wait); end
    tick();
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL idle ram_en: got %b want 0", ram_en); end
    tick();
  endtask

  task automatic test_lone_fetch();
    logic exp_en;
    apply_reset();
    if_req  = 1'b1;
    if_addr = 32'h10;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      exp_en = (c == 1 || c == 2);
      checks++; if (ram_en !== exp_en) begin errors++; $display("[TB] FAIL lone_fetch ram_en c%0d: got %b want %b", c, ram_en, exp_en); end
      if (exp_en) begin
        checks++; if (ram_addr !== 32'h10 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL lone_fetch ram_addr/we c%0d: got %h/%b want 00000010/0", c, ram_addr, ram_we); end
      end
      checks++; if (if_ready !== (c == 3)) begin errors++; $display("[TB] FAIL lone_fetch if_ready c%0d: got %b want %b", c, if_ready, (c == 3)); end
      checks++; if (pipe_stall !== (c < 3)) begin errors++; $display("[TB] FAIL lone_fetch pipe_stall c%0d: got %b want %b", c, pipe_stall, (c < 3)); end
      if (c == 3) begin
        checks++; if (if_rdata !== 32'hA500_0010) begin errors++; $display("[TB] FAIL lone_fetch if_rdata: got %h want a5000010", if_rdata); end
      end
      tick();
    end
    if_req = 1'b0;
  endtask

  // Runs right after test_lone_fetch, so if_rdata starts out holding the
  // previous fetch. Reset must clear it and must suppress the ready pulse.
  task automatic test_reset_mid();
    logic exp_en;
    if_req  = 1'b1;
    if_addr = 32'h30;
    for (int c = 0; c <= 7; c++) begin
      if (c == 2) clrn = 1'b1;
      if (c == 3) clrn = 1'b0;
      if (c == 7) if_req = 1'b0;
      @(negedge clk);
      exp_en = (c == 1 || c == 2 || c == 4 || c == 5);
      checks++; if (ram_en !== exp_en) begin errors++; $display("[TB] FAIL reset_mid ram_en c%0d: got %b want %b", c, ram_en, exp_en); end
      checks++; if (if_ready !== (c == 6)) begin errors++; $display("[TB] FAIL reset_mid if_ready c%0d: got %b want %b", c, if_ready, (c == 6)); end
      if (c == 3) begin
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid if_rdata cleared: got %h want 0", if_rdata); end
        checks++; if (pipe_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid pipe_stall: got %b want 1", pipe_stall); end
      end
      if (c == 6) begin
        checks++; if (if_rdata !== 32'hA500_0030) begin errors++; $display("[TB] FAIL reset_mid if_rdata: got %h want a5000030", if_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic        exp_en;
    logic [31:0] exp_if_wait;
    logic [31:0] exp_mem_wait;
`ifdef ARB_PERF_CNT_EN
    exp_if_wait  = 32'd6;
    exp_mem_wait = 32'd3;
`else
    exp_if_wait  = 32'd0;
    exp_mem_wait = 32'd0;
`endif
    apply_reset();
    if_req   = 1'b1;
    if_addr  = 32'h20;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h40;
    for (int c = 0; c <= 7; c++) begin
      if (c == 4) mem_req = 1'b0;
      if (c == 7) if_req = 1'b0;
      @(negedge clk);
      exp_en = (c == 1 || c == 2 || c == 4 || c == 5);
      checks++; if (ram_en !== exp_en) begin errors++; $display("[TB] FAIL simul ram_en c%0d: got %b want %b", c, ram_en, exp_en); end
      if (c == 1 || c == 2) begin
        checks++; if (ram_addr !== 32'h40) begin errors++; $display("[TB] FAIL simul mem ram_addr c%0d: got %h want 00000040", c, ram_addr); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (ram_addr !== 32'h20) begin errors++; $display("[TB] FAIL simul if ram_addr c%0d: got %h want 00000020", c, ram_addr); end
      end
      checks++; if (mem_ready !== (c == 3)) begin errors++; $display("[TB] FAIL simul mem_ready c%0d: got %b want %b", c, mem_ready, (c == 3)); end
      checks++; if (if_ready !== (c == 6)) begin errors++; $display("[TB] FAIL simul if_ready c%0d: got %b want %b", c, if_ready, (c == 6)); end
      checks++; if (pipe_stall !== (c < 6)) begin errors++; $display("[TB] FAIL simul pipe_stall c%0d: got %b want %b", c, pipe_stall, (c < 6)); end
      if (c == 3) begin
        checks++; if (mem_rdata !== 32'hA500_0040) begin errors++; $display("[TB] FAIL simul mem_rdata: got %h want a5000040", mem_rdata); end
      end
      if (c == 6) begin
        checks++; if (if_rdata !== 32'hA500_0020) begin errors++; $display("[TB] FAIL simul if_rdata: got %h want a5000020", if_rdata); end
      end
      if (c == 7) begin
        checks++; if (perf_if_wait !== exp_if_wait) begin errors++; $display("[TB] FAIL simul perf_if_wait: got %0d want %0d", perf_if_wait, exp_if_wait); end
        checks++; if (perf_mem_wait !== exp_mem_wait) begin errors++; $display("[TB] FAIL simul perf_mem_wait: got %0d want %0d", perf_mem_wait, exp_mem_wait); end
      end
      tick();
    end
  endtask

  // MEM requests continuously. IF requests too, but withdraws in the cycles
  // where MEM's ready is high; otherwise IF would win there by default. MEM
  // therefore takes grants at cycles 0, 4, 8 and 12, and the starvation
  // counter saturates. IF is forced through at cycle 16, and MEM resumes at
  // cycle 19.
  task automatic test_starvation();
    logic exp_mr;
    apply_reset();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h50;
    if_addr  = 32'h60;
    for (int c = 0; c <= 23; c++) begin
      if_req = !(c == 3 || c == 7 || c == 11 || c == 15);
      @(negedge clk);
      exp_mr = (c == 3 || c == 7 || c == 11 || c == 15 || c == 22);
      checks++; if (mem_ready !== exp_mr) begin errors++; $display("[TB] FAIL starve mem_ready c%0d: got %b want %b", c, mem_ready, exp_mr); end
      checks++; if (if_ready !== (c == 19)) begin errors++; $display("[TB] FAIL starve if_ready c%0d: got %b want %b", c, if_ready, (c == 19)); end
      if (c == 17) begin
        checks++; if (ram_addr !== 32'h60 || ram_en !== 1'b1) begin errors++; $display("[TB] FAIL starve forced IF grant: got addr=%h en=%b want 00000060/1", ram_addr, ram_en); end
      end
      if (c == 20) begin
        checks++; if (ram_addr !== 32'h50 || ram_en !== 1'b1) begin errors++; $display("[TB] FAIL starve MEM resume: got addr=%h en=%b want 00000050/1", ram_addr, ram_en); end
      end
      tick();
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  // Load 0x44, then store DEADBEEF to 0x80, then load 0x80. Each request
  // follows the previous ready pulse.
  task automatic test_store();
    logic exp_en;
    logic exp_we;
    apply_reset();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h44;
    for (int c = 0; c <= 12; c++) begin
      if (c == 4) begin
        mem_we    = 1'b1;
        mem_addr  = 32'h80;
        mem_wdata = 32'hDEAD_BEEF;
      end
      if (c == 8) begin
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
      end
      if (c == 12) mem_req = 1'b0;
      @(negedge clk);
      exp_en = (c == 1 || c == 2 || c == 5 || c == 6 || c == 9 || c == 10);
      exp_we = (c == 5 || c == 6);
      checks++; if (ram_en !== exp_en) begin errors++; $display("[TB] FAIL store ram_en c%0d: got %b want %b", c, ram_en, exp_en); end
      checks++; if (ram_we !== exp_we) begin errors++; $display("[TB] FAIL store ram_we c%0d: got %b want %b", c, ram_we, exp_we); end
      if (exp_we) begin
        checks++; if (ram_addr !== 32'h80 || ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store ram_addr/wdata c%0d: got %h/%h want 00000080/deadbeef", c, ram_addr, ram_wdata); end
      end
      checks++; if (mem_ready !== (c == 3 || c == 7 || c == 11)) begin errors++; $display("[TB] FAIL store mem_ready c%0d: got %b want %b", c, mem_ready, (c == 3 || c == 7 || c == 11)); end
      if (c >= 3 && c <= 10) begin
        checks++; if (mem_rdata !== 32'hA500_0044) begin errors++; $display("[TB] FAIL store mem_rdata held c%0d: got %h want a5000044", c, mem_rdata); end
      end
      if (c == 11) begin
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store readback: got %h want deadbeef", mem_rdata); end
      end
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] pipe_mem_arbiter directed test start");
    test_reset();
    test_lone_fetch();
    test_reset_mid();
    test_simultaneous();
    test_starvation();
    test_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
